// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, register IDs and instruction codes.
package y86_pkg;

  typedef enum logic [3:0] {
    SBUB = 4'h0,
    SAOK = 4'h1,
    SHLT = 4'h2,
    SADR = 4'h3,
    SINS = 4'h4
  } stat_e;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  function automatic logic is_exception(input logic [3:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Architectural register array: two write ports (M wins on collision),
// two combinational read ports with optional write-through bypass.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int unsigned NREG      = 15,
  parameter bit          WR_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e,
  input  logic [3:0]  waddr_e,
  input  logic [63:0] wdata_e,
  input  logic        we_m,
  input  logic [3:0]  waddr_m,
  input  logic [63:0] wdata_m,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [63:0] rdata_a,
  output logic [63:0] rdata_b
);

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];

  // M is applied after E so a shared destination keeps ValM.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (we_e) regs_d[waddr_e] = wdata_e;
    if (we_m) regs_d[waddr_m] = wdata_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  function automatic logic [63:0] read_port(input logic [3:0] addr);
    logic [63:0] val;
    val = '0;
    if (addr != RNONE) begin
      if (WR_BYPASS && we_m && (waddr_m == addr))      val = wdata_m;
      else if (WR_BYPASS && we_e && (waddr_e == addr)) val = wdata_e;
      else                                             val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: commits W results into the register file and
// tracks sticky status plus retire/cycle counters.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int unsigned NREG      = 15,
  parameter bit          WR_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  W_stat,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_ValE,
  input  logic [63:0] W_ValM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [3:0]  Stat,
  output logic        halted,
  output logic [63:0] retired,
  output logic [63:0] cycles
);

  stat_e       stat_q, stat_d;
  logic        halted_q, halted_d;
  logic [63:0] retired_q, retired_d;
  logic [63:0] cycles_q, cycles_d;
  logic        commit;
  logic        unused_icode;

  // icode is carried through W for tracing only; write-back needs none of it.
  assign unused_icode = ^W_icode;

  assign commit = !halted_q && ((W_stat == SAOK) || (W_stat == SBUB));

  regfile_2r2w #(
    .NREG      (NREG),
    .WR_BYPASS (WR_BYPASS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_e    (commit && (W_dstE != RNONE)),
    .waddr_e (W_dstE),
    .wdata_e (W_ValE),
    .we_m    (commit && (W_dstM != RNONE)),
    .waddr_m (W_dstM),
    .wdata_m (W_ValM),
    .raddr_a (d_srcA),
    .raddr_b (d_srcB),
    .rdata_a (d_rvalA),
    .rdata_b (d_rvalB)
  );

  always_comb begin
    stat_d    = stat_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    cycles_d  = cycles_q;
    if (!halted_q) begin
      cycles_d = cycles_q + 64'd1;
      if (is_exception(W_stat)) begin
        stat_d   = stat_e'(W_stat);
        halted_d = 1'b1;
      end
      if (commit && (W_stat == SAOK)) retired_d = retired_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q    <= SAOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      stat_q    <= stat_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign Stat    = stat_q;
  assign halted  = halted_q;
  assign retired = retired_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_ValE;
  logic [63:0] W_ValM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [3:0]  Stat;
  logic        halted;
  logic [63:0] retired;
  logic [63:0] cycles;

  writeback_regfile #(
    .NREG      (15),
    .WR_BYPASS (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .W_stat  (W_stat),
    .W_icode (W_icode),
    .W_ValE  (W_ValE),
    .W_ValM  (W_ValM),
    .W_dstE  (W_dstE),
    .W_dstM  (W_dstM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB),
    .Stat    (Stat),
    .halted  (halted),
    .retired (retired),
    .cycles  (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {SEL_RVALA, SEL_RVALB, SEL_STAT, SEL_HALTED, SEL_RETIRED, SEL_CYCLES} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_cyc = '0;
  bit          halt_m  = 1'b0;

  task automatic expect_val(input string name, input sel_e sel, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  // Edge-count model: one per rising edge while out of reset and not halted.
  task automatic tick();
    @(posedge clk);
    if (rst_n && !halt_m) exp_cyc = exp_cyc + 64'd1;
    #1;
  endtask

  task automatic w_drive(input logic [3:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    W_stat = st;
    W_dstE = de;
    W_ValE = ve;
    W_dstM = dm;
    W_ValM = vm;
  endtask

  task automatic w_idle();
    w_drive(4'h0, 4'hF, '0, 4'hF, '0);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [63:0] act;
      c = sb.pop_front();
      case (c.sel)
        SEL_RVALA:   act = d_rvalA;
        SEL_RVALB:   act = d_rvalB;
        SEL_STAT:    act = {60'd0, Stat};
        SEL_HALTED:  act = {63'd0, halted};
        SEL_RETIRED: act = retired;
        default:     act = cycles;
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    W_icode = 4'h1;
    d_srcA  = 4'hF;
    d_srcB  = 4'hF;
    w_idle();
    tick();
    tick();
    rst_n   = 1'b1;
    exp_cyc = '0;

    // Reset state: every ID plus RNONE reads 0
    expect_val("rst_stat", SEL_STAT, 64'd1);
    expect_val("rst_halted", SEL_HALTED, 64'd0);
    expect_val("rst_retired", SEL_RETIRED, 64'd0);
    expect_val("rst_cycles", SEL_CYCLES, 64'd0);
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(15 - i);
      expect_val($sformatf("rst_rA_%0d", i), SEL_RVALA, 64'd0);
      expect_val($sformatf("rst_rB_%0d", 15 - i), SEL_RVALB, 64'd0);
      tick();
    end

    // Single E write, visible next cycle
    w_drive(4'h1, 4'h2, 64'h1234, 4'hF, '0);
    tick();
    w_idle();
    d_srcA = 4'h2;
    expect_val("wrE_reg2", SEL_RVALA, 64'h1234);
    expect_val("wrE_retired", SEL_RETIRED, 64'd1);
    tick();

    // E and M to same register: M wins, also through the bypass
    w_drive(4'h1, 4'h4, 64'h100, 4'h4, 64'h200);
    d_srcB = 4'h4;
    expect_val("popq_bypass", SEL_RVALB, 64'h200);
    expect_val("reg2_hold", SEL_RVALA, 64'h1234);
    tick();
    w_idle();
    d_srcA = 4'h4;
    expect_val("popq_stored", SEL_RVALA, 64'h200);
    expect_val("popq_retired", SEL_RETIRED, 64'd2);
    tick();

    // Bubbles still write but do not retire
    for (int i = 0; i < 5; i++) begin
      w_drive(4'h0, 4'h3, 64'd7, 4'hF, '0);
      tick();
    end
    w_idle();
    d_srcA = 4'h3;
    expect_val("bub_reg3", SEL_RVALA, 64'd7);
    expect_val("bub_retired", SEL_RETIRED, 64'd2);
    expect_val("bub_stat", SEL_STAT, 64'd1);
    expect_val("bub_cycles", SEL_CYCLES, exp_cyc);
    tick();

    // Three retirements, then halt
    for (int i = 0; i < 3; i++) begin
      w_drive(4'h1, 4'h6, 64'(64'hA0 + i), 4'hF, '0);
      tick();
    end
    w_drive(4'h2, 4'h1, 64'hDEAD, 4'hF, '0);
    d_srcA = 4'h1;
    expect_val("hlt_no_bypass", SEL_RVALA, 64'd0);
    expect_val("pre_hlt_retired", SEL_RETIRED, 64'd5);
    expect_val("pre_hlt_halted", SEL_HALTED, 64'd0);
    tick();
    halt_m = 1'b1;
    w_drive(4'h1, 4'h1, 64'hBEEF, 4'hF, '0);
    d_srcB = 4'h6;
    expect_val("hlt_reg1", SEL_RVALA, 64'd0);
    expect_val("hlt_stat", SEL_STAT, 64'd2);
    expect_val("hlt_halted", SEL_HALTED, 64'd1);
    expect_val("hlt_retired", SEL_RETIRED, 64'd5);
    expect_val("hlt_cycles", SEL_CYCLES, exp_cyc);
    expect_val("hlt_reg6", SEL_RVALB, 64'hA2);
    tick();
    expect_val("post_hlt_reg1", SEL_RVALA, 64'd0);
    expect_val("post_hlt_retired", SEL_RETIRED, 64'd5);
    expect_val("post_hlt_cycles", SEL_CYCLES, exp_cyc);
    expect_val("post_hlt_stat", SEL_STAT, 64'd2);
    tick();

    // Asynchronous reset between edges while halted
    w_idle();
    d_srcA = 4'h2;
    d_srcB = 4'h4;
    #2;
    rst_n = 1'b0;
    expect_val("arst_reg2", SEL_RVALA, 64'd0);
    expect_val("arst_reg4", SEL_RVALB, 64'd0);
    expect_val("arst_stat", SEL_STAT, 64'd1);
    expect_val("arst_halted", SEL_HALTED, 64'd0);
    expect_val("arst_retired", SEL_RETIRED, 64'd0);
    expect_val("arst_cycles", SEL_CYCLES, 64'd0);
    tick();
    rst_n   = 1'b1;
    halt_m  = 1'b0;
    exp_cyc = '0;
    w_drive(4'h1, 4'h5, 64'h55, 4'hF, '0);
    tick();
    w_idle();
    d_srcA = 4'h5;
    expect_val("rel_reg5", SEL_RVALA, 64'h55);
    expect_val("rel_retired", SEL_RETIRED, 64'd1);
    expect_val("rel_cycles", SEL_CYCLES, exp_cyc);
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage plus architectural register file for the Y86-64 pipeline.
- Sits directly downstream of the W pipeline register and consumes W_stat, W_icode, W_ValE, W_ValM, W_dstE and W_dstM.
- Commits results into the 15 program registers and supplies the decode-stage read ports.
- Keeps the sticky processor status and the retire/cycle counters used to stop simulation.

Parameters:
- NREG, 15, number of architectural registers (IDs 0..14; 4'hF = RNONE).
- WR_BYPASS, 0, if 1, decode reads return same-cycle write data (write-through); if 0, reads return the stored value only.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- W_stat  input  4  status of the instruction in W (SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4).
- W_icode  input  4  icode of the instruction in W.
- W_ValE  input  64  ALU result.
- W_ValM  input  64  memory read result.
- W_dstE  input  4  destination register for ValE (RNONE = no write).
- W_dstM  input  4  destination register for ValM (RNONE = no write).
- d_srcA  input  4  decode read address A.
- d_srcB  input  4  decode read address B.
- d_rvalA  output  64  register value at d_srcA (0 if RNONE).
- d_rvalB  output  64  register value at d_srcB (0 if RNONE).
- Stat  output  4  sticky processor status.
- halted  output  1  high once Stat != SAOK.
- retired  output  64  count of retired instructions.
- cycles  output  64  count of cycles since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 15 registers are cleared to 0.
  - Stat = SAOK, halted = 0, retired = 0, cycles = 0.
  - Takes effect immediately, including mid-operation; the first write after release is on the next rising edge with rst_n high.
- Commit enable: commit = !halted && (W_stat == SAOK || W_stat == SBUB).
- Writes (rising edge, when commit):
  - If W_dstE != RNONE, reg[W_dstE] <= W_ValE.
  - If W_dstM != RNONE, reg[W_dstM] <= W_ValM.
  - If W_dstE == W_dstM != RNONE, only W_ValM is written (popq %rsp semantics).
- Exceptional W_stat (SHLT/SADR/SINS): no register write that cycle, even if the dst fields are not RNONE.
- Status:
  - If !halted and W_stat in {SHLT, SADR, SINS}: Stat <= W_stat and halted <= 1 on that edge.
  - SBUB never changes Stat.
  - Once halted, Stat and halted hold until reset; later W inputs are ignored for writes, Stat and retired.
- Counters:
  - cycles increments on every edge while !halted. It counts the halting edge itself, then freezes.
  - retired increments when commit && W_stat == SAOK; bubbles are not counted.
  - Both counters wrap modulo 2^64.
- Reads (combinational):
  - d_rvalX = 0 when d_srcX == RNONE, otherwise reg[d_srcX].
  - WR_BYPASS = 1: if commit and d_srcX matches a write this cycle, return that write data, applying the same M-over-E priority.
  - WR_BYPASS = 0: the pipeline forwarding unit covers the W stage, so no bypass is needed.
- Latency: write visible to reads one cycle after the commit edge (zero cycles with bypass).
- W_stall is handled upstream. This block commits whatever is presented each edge, so a stalled W register re-presenting the same instruction re-writes identical data and counts it again. To avoid this, the W stage inserts a bubble or holds W_stat = SBUB on stall.

Decomposition:
- Shared package y86_pkg holds:
  - Stat codes SBUB/SAOK/SHLT/SADR/SINS.
  - Register IDs RRSP, RNONE (4'hF), etc.
  - icode constants (IHALT, INOP, IPOPQ, ...).
- One natural sub-module, regfile_2r2w: the 15x64 array with two write ports (M priority), two combinational read ports and an optional bypass.
- Status and counter logic stays in the top module.

Test Plan:
- Reset then release; read every register ID 0..14 and RNONE -> all 0; Stat = 1, halted = 0, retired = 0.
- W_stat=SAOK, W_dstE=2, W_ValE=64'h1234, W_dstM=RNONE, then next cycle d_srcA=2 -> d_rvalA = 64'h1234, retired = 1.
- W_dstE=W_dstM=4 (rsp), ValE=64'h100, ValM=64'h200 -> reg4 = 64'h200; WR_BYPASS=1 same-cycle read d_srcB=4 -> 64'h200.
- Retire three SAOK instructions, then W_stat=SHLT with W_dstE=1, ValE=64'hDEAD -> reg1 unchanged, Stat = 2, halted = 1, retired = 3. Next cycle W_stat=SAOK, dstE=1 -> still no write, retired stays 3, cycles frozen.
- Five SBUB cycles with dstE=3, ValE=7 -> reg3 = 7 written; retired unchanged; Stat stays 1.
- Assert rst_n low between edges while halted with nonzero registers -> outputs immediately 0 / SAOK; after release a normal SAOK write to reg5 succeeds.
